// File: rtl/key_debounce_bank.sv
// key_debounce_bank: N-channel push-button synchroniser/debouncer with level, press and release outputs.
// Optional auto-repeat on held keys is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_bank #(
  parameter int unsigned           N_KEYS          = 4,
  parameter int unsigned           CNT_W           = 20,
  parameter logic [CNT_W-1:0]      DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter bit                    ACTIVE_LOW      = 1'b1,
  parameter int unsigned           RPT_W           = 27,
  parameter logic [RPT_W-1:0]      REPEAT_DELAY    = 27'd25_000_000,
  parameter logic [RPT_W-1:0]      REPEAT_PERIOD   = 27'd5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);
  localparam logic [CNT_W-1:0] CNT_MAX = DEBOUNCE_CYCLES - 1'b1;
  typedef enum logic [1:0] {REL, PRESS_PEND, PRESSED, REL_PEND} state_t;
  logic [N_KEYS-1:0] meta_q, sync_q, s;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      meta_q <= {N_KEYS{ACTIVE_LOW}};
      sync_q <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      meta_q <= key_raw;
      sync_q <= meta_q;
    end
  assign s = ACTIVE_LOW ? ~sync_q : sync_q;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q, press_q, release_q, repeat_q;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
        state_q   <= REL;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          REL:
            if (s[i]) begin
              state_q <= PRESS_PEND;
              cnt_q   <= '0;
            end
          PRESS_PEND:
            if (!s[i]) begin
              state_q <= REL;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          PRESSED:
            if (!s[i]) begin
              state_q <= REL_PEND;
              cnt_q   <= '0;
            end
          REL_PEND:
            if (s[i]) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q   <= REL;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          default: state_q <= REL;
        endcase
      end
`ifdef KEY_AUTOREPEAT_EN
    // Hold time accrues on every pressed sample while debounced-pressed; reload keeps later repeats one period apart.
    localparam logic [RPT_W-1:0] RPT_MAX    = REPEAT_DELAY - 1'b1;
    localparam logic [RPT_W-1:0] RPT_RELOAD = REPEAT_DELAY - REPEAT_PERIOD;
    logic [RPT_W-1:0] rpt_q;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
        rpt_q    <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (state_q == REL || state_q == PRESS_PEND) rpt_q <= '0;
        else if (s[i]) begin
          rpt_q    <= (rpt_q == RPT_MAX) ? RPT_RELOAD : rpt_q + 1'b1;
          repeat_q <= (rpt_q == RPT_MAX);
        end
      end
`else
    assign repeat_q = 1'b0;
`endif
    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q | repeat_q;
    assign key_release[i] = release_q;
    assign key_repeat[i]  = repeat_q;
  end
`ifndef KEY_AUTOREPEAT_EN
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD, RPT_W[0]};
`endif
endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank: directed + random stimulus checked against a run-length debounce model.
module tb_key_debounce_bank;
  localparam int N = 4, D = 5, RD = 10, RP = 4;
  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [3:0] key_raw  = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  always #5 CLOCK_50 = ~CLOCK_50;
  key_debounce_bank #(
    .N_KEYS(4), .CNT_W(20), .DEBOUNCE_CYCLES(20'd5), .ACTIVE_LOW(1'b1),
    .RPT_W(27), .REPEAT_DELAY(27'd10), .REPEAT_PERIOD(27'd4)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: raw pins pass through two sample delays; a level flips once the
  // synced value has disagreed with it for D+1 consecutive samples.
  logic [3:0] m_sy1, m_sy2, e_lvl, e_prs, e_rel, e_rpt;
  int run[N], held[N];
  task automatic m_reset();
    m_sy1 = 4'hF; m_sy2 = 4'hF;
    e_lvl = '0; e_prs = '0; e_rel = '0; e_rpt = '0;
    for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; end
  endtask
  task automatic m_clock(input logic [3:0] r);
    logic [3:0] s;
    s = ~m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = r;
    e_prs = '0; e_rel = '0; e_rpt = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != e_lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          e_lvl[i] = s[i];
          run[i] = 0;
          held[i] = 0;
          if (s[i]) e_prs[i] = 1'b1; else e_rel[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
        if (e_lvl[i] && s[i]) begin
          held[i]++;
`ifdef KEY_AUTOREPEAT_EN
          if (held[i] >= RD && (held[i] - RD) % RP == 0) begin
            e_prs[i] = 1'b1;
            e_rpt[i] = 1'b1;
          end
`endif
        end
      end
    end
  endtask
  task automatic step();
    logic [3:0] r;
    r = key_raw;
    @(posedge CLOCK_50);
    if (RESET_N) m_clock(r);
    #1;
    chk("level", key_level, e_lvl);
    chk("press", key_press, e_prs);
    chk("release", key_release, e_rel);
    chk("repeat", key_repeat, e_rpt);
  endtask
  task automatic do_reset();
    #2 RESET_N = 1'b0;
    m_reset();
    #1;
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_release", key_release, 0);
    chk("rst_repeat", key_repeat, 0);
    repeat (2) @(posedge CLOCK_50);
    #3 RESET_N = 1'b1;
  endtask
  int lat, np, nr, nx;
  logic [3:0] first_p;
  initial begin
    m_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("init_level", key_level, 0);
    chk("init_press", key_press, 0);
    chk("init_release", key_release, 0);
    chk("init_repeat", key_repeat, 0);
    #3 RESET_N = 1'b1;
    repeat (3) step();
    // reset in the middle of a pending press
    key_raw[0] = 1'b0;
    repeat (4) step();
    key_raw[0] = 1'b1;
    do_reset();
    np = 0;
    for (int c = 0; c < 12; c++) begin step(); if (key_press[0]) np++; end
    chk("rst_abort_press", np, 0);
    // clean press on channel 1
    key_raw[1] = 1'b0;
    lat = 0; np = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (key_press[1]) begin np++; if (lat == 0) lat = c; end
    end
    chk("press_lat", lat, 8);
    chk("press_cnt", np, 1);
    chk("press_level", key_level[1], 1);
    // release on channel 1
    key_raw[1] = 1'b1;
    lat = 0; nr = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (key_release[1]) begin nr++; if (lat == 0) lat = c; end
    end
    chk("rel_lat", lat, 8);
    chk("rel_cnt", nr, 1);
    chk("rel_level", key_level[1], 0);
    // short glitch on channel 2
    key_raw[2] = 1'b0;
    np = 0;
    repeat (3) begin step(); if (key_press[2]) np++; end
    key_raw[2] = 1'b1;
    repeat (10) begin step(); if (key_press[2] || key_level[2]) np++; end
    chk("glitch", np, 0);
    // bounce then stable press on channel 2
    key_raw[2] = 1'b0; step();
    key_raw[2] = 1'b1; step();
    key_raw[2] = 1'b0;
    lat = 0; np = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (key_press[2]) begin np++; if (lat == 0) lat = c; end
    end
    chk("bounce_lat", lat, 8);
    chk("bounce_cnt", np, 1);
    key_raw[2] = 1'b1;
    repeat (12) step();
    // simultaneous presses on channels 3..1
    key_raw[3:1] = 3'b000;
    first_p = '0; np = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (key_press != 0 && first_p == 0) first_p = key_press;
      if (key_press[0]) np++;
    end
    chk("simul", first_p, 4'b1110);
    chk("simul_ch0", np, 0);
    key_raw = 4'hF;
    repeat (12) step();
    // long hold on channel 1
    key_raw[1] = 1'b0;
    repeat (8) step();
    chk("hold_press", key_press[1], 1);
    np = 0; nx = 0;
    for (int c = 1; c <= 29; c++) begin
      step();
      if (key_press[1]) np++;
      if (key_repeat[1]) nx++;
    end
`ifdef KEY_AUTOREPEAT_EN
    chk("hold_repeats", nx, 5);
    chk("hold_presses", np, 5);
`else
    chk("hold_repeats", nx, 0);
    chk("hold_presses", np, 0);
`endif
    key_raw[1] = 1'b1;
    repeat (12) step();
    // random bouncing on all channels with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) key_raw[i] = ~key_raw[i];
      if ($urandom_range(499) == 0) do_reset();
      step();
      chk("excl", key_press & key_release, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
